wb_trace_checker: RTL and testbench
===================================

# wb_trace_checker

Consumer end of the CPU's writeback debug trace (`debug_wb_have_inst`, `debug_wb_pc`, `debug_wb_ena`, `debug_wb_reg`, `debug_wb_value`). Buffers each retired instruction in a small FIFO and compares it in order against a golden trace entry delivered over a valid/ready port. Reports pass count, first mismatch, FIFO overflow and completion. Instantiated beside `top` in simulation and FPGA self-test builds.

## Interface
- `DEPTH`, 8, commit FIFO entries; power of two, ≥2
- `clk_i` input 1 — single clock, rising edge
- `rst` input 1 — asynchronous, active-high reset
- `debug_wb_have_inst` input 1 — a commit is present this cycle
- `debug_wb_pc` input 32 — PC of committed instruction
- `debug_wb_ena` input 1 — commit writes the register file
- `debug_wb_reg` input 5 — destination register
- `debug_wb_value` input 32 — write data
- `gold_valid` input 1 — golden entry available
- `gold_ready` output 1 — golden entry consumed this cycle
- `gold_pc` input 32, `gold_ena` input 1, `gold_reg` input 5, `gold_value` input 32 — expected commit
- `gold_last` input 1 — this golden entry is the final one
- `chk_done` output 1 — last entry matched
- `chk_fail` output 1 — mismatch detected (sticky)
- `chk_overflow` output 1 — commit dropped, FIFO full (sticky)
- `chk_pass_cnt` output 32 — matched entries
- `err_pc` output 32, `err_reg` output 5, `err_exp_value` output 32, `err_got_value` output 32 — captured first mismatch (DUT PC, DUT reg, golden value, DUT value)

## Operation
- States: RUN (reset state), FAIL, DONE. `chk_fail` = (state==FAIL). `chk_done` = (state==DONE).
- Push: in every state except FAIL/DONE, a cycle with `debug_wb_have_inst`=1 writes {pc, ena, reg, value} to the FIFO. Cycles with `have_inst`=0 are ignored, regardless of the other debug inputs.
- Pop/compare: in RUN, when the FIFO is non-empty and `gold_valid`=1, `gold_ready`=1 combinationally. The head entry is popped and compared with the golden entry in the same cycle. Otherwise `gold_ready`=0.
- Match rule: PC equal AND ena equal AND, if `gold_ena`=1 and `gold_reg`≠0, reg equal and value equal. When `gold_ena`=0 or `gold_reg`=0, reg and value are don't-care.
- Match: `chk_pass_cnt` += 1 (wraps at 2^32). If `gold_last`=1, the next state is DONE.
- Mismatch: next state is FAIL. `err_*` are loaded once, from the DUT head entry and `gold_value`. `chk_pass_cnt` is not incremented.
- Overflow: a push while the FIFO is full and no pop happens in the same cycle drops the commit and sets `chk_overflow`. State is unaffected. A push to a full FIFO with a simultaneous pop is accepted.
- FAIL and DONE are terminal; only `rst` leaves them. In these states no pushes or pops occur, and `err_*` and `chk_pass_cnt` hold their values.
- FIFO occupancy counter is `$clog2(DEPTH)+1` bits. Read and write pointers wrap modulo DEPTH.

## Timing
- Reset (async assert): state RUN, FIFO empty, `gold_ready`=0, `chk_done`=0, `chk_fail`=0, `chk_overflow`=0, `chk_pass_cnt`=0, all `err_*`=0.
- Reset mid-run flushes the FIFO and clears all sticky flags immediately. After deassertion, checking restarts from a fresh golden stream.
- A commit pushed at edge N is poppable in cycle N+1; a commit can never be compared in its own push cycle. Minimum latency from commit to counter or flag update is 2 edges.
- Throughput: one push and one pop per cycle sustained.
- Golden side: the entry is consumed only on a cycle with `gold_valid`&&`gold_ready`. The golden source must hold its data stable while `gold_valid`=1 and `gold_ready`=0.
- Flag and counter updates are registered and visible the cycle after the compare cycle.

## Test plan
- Match stream: 5 commits (PC 0x0,0x4,…,0x10, x1..x5 ← 1..5) with identical golden entries, last flagged -> `chk_pass_cnt`=5, `chk_done`=1, `chk_fail`=0.
- Value mismatch: golden 3rd entry value 0x3 vs DUT 0x7, x3, PC 0x8 -> `chk_fail`=1, `err_pc`=0x8, `err_reg`=3, `err_exp_value`=3, `err_got_value`=7, `chk_pass_cnt`=2. Later commits are ignored.
- Don't-care rule: commit to x0 with value 0xDEAD, golden value 0 -> passes. Store with ena=0 and random reg/value -> passes. ena mismatch -> fails.
- Overflow: hold `gold_valid`=0 and issue DEPTH+1 back-to-back commits -> `chk_overflow`=1 on the (DEPTH+1)th. Then release golden -> DEPTH entries compare.
- Full with simultaneous push/pop: FIFO full, `gold_valid`=1, commit in the same cycle -> no overflow, occupancy stays DEPTH.
- Reset mid-run: assert `rst` between edges with 3 entries queued and `chk_fail`=1 -> all outputs 0 immediately, FIFO empty. A fresh 2-entry match then gives `chk_pass_cnt`=2, `chk_done`=1.

Source files
------------

// File: rtl/wb_trace_checker.sv
// Writeback trace checker: buffers retired instructions in a small FIFO and
// compares them in order against a golden trace delivered over valid/ready.
module wb_trace_checker #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        debug_wb_have_inst,
  input  logic [31:0] debug_wb_pc,
  input  logic        debug_wb_ena,
  input  logic [4:0]  debug_wb_reg,
  input  logic [31:0] debug_wb_value,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic        gold_ena,
  input  logic [4:0]  gold_reg,
  input  logic [31:0] gold_value,
  input  logic        gold_last,
  output logic        chk_done,
  output logic        chk_fail,
  output logic        chk_overflow,
  output logic [31:0] chk_pass_cnt,
  output logic [31:0] err_pc,
  output logic [4:0]  err_reg,
  output logic [31:0] err_exp_value,
  output logic [31:0] err_got_value
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FAIL,
    ST_DONE
  } state_t;

  state_t state;

  logic [31:0] mem_pc    [DEPTH];
  logic        mem_ena   [DEPTH];
  logic [4:0]  mem_reg   [DEPTH];
  logic [31:0] mem_value [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        full;
  logic        empty;
  logic        match;
  logic [31:0] head_pc;
  logic        head_ena;
  logic [4:0]  head_reg;
  logic [31:0] head_value;

  assign chk_fail = (state == ST_FAIL);
  assign chk_done = (state == ST_DONE);

  always_comb begin
    head_pc    = mem_pc[rd_ptr];
    head_ena   = mem_ena[rd_ptr];
    head_reg   = mem_reg[rd_ptr];
    head_value = mem_value[rd_ptr];
    push_req   = debug_wb_have_inst && (state == ST_RUN);
    full       = (count == CW'(DEPTH));
    empty      = (count == '0);
    gold_ready = (state == ST_RUN) && !empty && gold_valid;
    pop        = gold_ready;
    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    push_ok    = push_req && (!full || pop);
    match      = (head_pc == gold_pc) && (head_ena == gold_ena) &&
                 (!(gold_ena && (gold_reg != 5'd0)) ||
                  ((head_reg == gold_reg) && (head_value == gold_value)));
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_pc[wr_ptr]    <= debug_wb_pc;
      mem_ena[wr_ptr]   <= debug_wb_ena;
      mem_reg[wr_ptr]   <= debug_wb_reg;
      mem_value[wr_ptr] <= debug_wb_value;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      chk_overflow  <= 1'b0;
      chk_pass_cnt  <= '0;
      err_pc        <= '0;
      err_reg       <= '0;
      err_exp_value <= '0;
      err_got_value <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);

      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (push_req && full && !pop) chk_overflow <= 1'b1;

      if (pop) begin
        if (match) begin
          chk_pass_cnt <= chk_pass_cnt + 32'd1;
          if (gold_last) state <= ST_DONE;
        end else begin
          state         <= ST_FAIL;
          err_pc        <= head_pc;
          err_reg       <= head_reg;
          err_exp_value <= gold_value;
          err_got_value <= head_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Scoreboard bench for wb_trace_checker: a queue models the commit FIFO and
// expected results are queued at each golden handshake, checked after the edge.
module tb_wb_trace_checker;

  localparam int unsigned DEPTH = 8;

  logic        clk_i;
  logic        rst;
  logic        debug_wb_have_inst;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_ena;
  logic [4:0]  debug_wb_reg;
  logic [31:0] debug_wb_value;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic        gold_ena;
  logic [4:0]  gold_reg;
  logic [31:0] gold_value;
  logic        gold_last;
  logic        chk_done;
  logic        chk_fail;
  logic        chk_overflow;
  logic [31:0] chk_pass_cnt;
  logic [31:0] err_pc;
  logic [4:0]  err_reg;
  logic [31:0] err_exp_value;
  logic [31:0] err_got_value;

  wb_trace_checker #(.DEPTH(DEPTH)) dut (
    .clk_i              (clk_i),
    .rst                (rst),
    .debug_wb_have_inst (debug_wb_have_inst),
    .debug_wb_pc        (debug_wb_pc),
    .debug_wb_ena       (debug_wb_ena),
    .debug_wb_reg       (debug_wb_reg),
    .debug_wb_value     (debug_wb_value),
    .gold_valid         (gold_valid),
    .gold_ready         (gold_ready),
    .gold_pc            (gold_pc),
    .gold_ena           (gold_ena),
    .gold_reg           (gold_reg),
    .gold_value         (gold_value),
    .gold_last          (gold_last),
    .chk_done           (chk_done),
    .chk_fail           (chk_fail),
    .chk_overflow       (chk_overflow),
    .chk_pass_cnt       (chk_pass_cnt),
    .err_pc             (err_pc),
    .err_reg            (err_reg),
    .err_exp_value      (err_exp_value),
    .err_got_value      (err_got_value)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] val;
  } ent_t;

  typedef struct {
    logic [31:0] pass;
    logic        fail;
    logic        done;
  } exp_t;

  ent_t cq[$];
  exp_t eq[$];

  int          tests = 0;
  int          fails = 0;
  int          waits = 0;
  int          m_state = 0;  // 0 run, 1 fail, 2 done
  logic [31:0] m_pass = '0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_err_pc, m_err_exp, m_err_got;
  logic [4:0]  m_err_reg;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    cq.delete();
    eq.delete();
    m_state = 0;
    m_pass  = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk_i);
    rst = 1'b0;
    @(negedge clk_i);
  endtask

  // Drives one commit for one cycle; starts and ends at a falling edge.
  task automatic commit(input logic [31:0] pc, input logic ena,
                        input logic [4:0] rg, input logic [31:0] val);
    ent_t e;
    debug_wb_have_inst = 1'b1;
    debug_wb_pc        = pc;
    debug_wb_ena       = ena;
    debug_wb_reg       = rg;
    debug_wb_value     = val;
    @(negedge clk_i);
    debug_wb_have_inst = 1'b0;
    debug_wb_pc        = $urandom;
    debug_wb_ena       = 1'($urandom);
    debug_wb_reg       = 5'($urandom);
    debug_wb_value     = $urandom;
    if (m_state == 0) begin
      if (cq.size() < DEPTH) begin
        e.pc = pc; e.ena = ena; e.rg = rg; e.val = val;
        cq.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // Offers one golden entry until accepted; checks results after the edge.
  task automatic gold_xfer(input logic [31:0] pc, input logic ena,
                           input logic [4:0] rg, input logic [31:0] val,
                           input logic last);
    ent_t h;
    exp_t e;
    bit   exp_rdy;
    bit   ok;
    bit   taken = 1'b0;
    gold_valid = 1'b1;
    gold_pc    = pc;
    gold_ena   = ena;
    gold_reg   = rg;
    gold_value = val;
    gold_last  = last;
    for (int i = 0; i < 20 && !taken; i++) begin
      #1;
      exp_rdy = (m_state == 0) && (cq.size() > 0);
      tests++;
      if (gold_ready !== exp_rdy) begin
        fails++;
        $display("FAIL gold_ready: got %b expected %b", gold_ready, exp_rdy);
      end
      if (gold_ready && exp_rdy) begin
        h  = cq.pop_front();
        ok = (h.pc == pc) && (h.ena == ena) &&
             (!(ena && (rg != 5'd0)) || ((h.rg == rg) && (h.val == val)));
        if (ok) begin
          m_pass = m_pass + 32'd1;
          if (last) m_state = 2;
        end else begin
          m_state   = 1;
          m_err_pc  = h.pc;
          m_err_reg = h.rg;
          m_err_exp = val;
          m_err_got = h.val;
        end
        e.pass = m_pass;
        e.fail = (m_state == 1);
        e.done = (m_state == 2);
        eq.push_back(e);
        taken = 1'b1;
      end else begin
        waits++;
      end
      @(negedge clk_i);
    end
    gold_valid = 1'b0;
    gold_pc    = $urandom;
    gold_value = $urandom;
    if (!taken) begin
      tests++;
      fails++;
      $display("FAIL gold_timeout: entry pc=%h never accepted", pc);
    end else begin
      e = eq.pop_front();
      tests++;
      if (chk_pass_cnt !== e.pass || chk_fail !== e.fail || chk_done !== e.done) begin
        fails++;
        $display("FAIL compare_result pc=%h: got cnt=%0d fail=%b done=%b expected cnt=%0d fail=%b done=%b",
                 pc, chk_pass_cnt, chk_fail, chk_done, e.pass, e.fail, e.done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gold_valid = 1'b1;
    #1;
    tests++;
    if ({gold_ready, chk_done, chk_fail, chk_overflow} !== 4'b0 || chk_pass_cnt !== '0 ||
        err_pc !== '0 || err_reg !== '0 || err_exp_value !== '0 || err_got_value !== '0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b done=%b fail=%b ovf=%b cnt=%0d required all zero",
               gold_ready, chk_done, chk_fail, chk_overflow, chk_pass_cnt);
    end
    gold_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_match_stream();
    do_reset();
    for (int i = 0; i < 5; i++) commit(32'(4 * i), 1'b1, 5'(i + 1), 32'(i + 1));
    for (int i = 0; i < 5; i++) gold_xfer(32'(4 * i), 1'b1, 5'(i + 1), 32'(i + 1), i == 4);
    tests++;
    if (chk_pass_cnt !== 32'd5 || chk_done !== 1'b1 || chk_fail !== 1'b0) begin
      fails++;
      $display("FAIL match_stream: cnt=%0d done=%b fail=%b required 5/1/0",
               chk_pass_cnt, chk_done, chk_fail);
    end
  endtask

  task automatic test_value_mismatch();
    logic [31:0] dv;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dv = (i == 2) ? 32'd7 : 32'(i + 1);
      commit(32'(4 * i), 1'b1, 5'(i + 1), dv);
    end
    for (int i = 0; i < 3; i++) gold_xfer(32'(4 * i), 1'b1, 5'(i + 1), 32'(i + 1), 1'b0);
    tests++;
    if (chk_fail !== 1'b1 || err_pc !== 32'h8 || err_reg !== 5'd3 ||
        err_exp_value !== 32'd3 || err_got_value !== 32'd7 || chk_pass_cnt !== 32'd2) begin
      fails++;
      $display("FAIL value_mismatch: fail=%b pc=%h reg=%0d exp=%h got=%h cnt=%0d required 1/8/3/3/7/2",
               chk_fail, err_pc, err_reg, err_exp_value, err_got_value, chk_pass_cnt);
    end
    commit(32'h40, 1'b1, 5'd9, 32'h99);
    gold_valid = 1'b1;
    gold_pc = 32'hC; gold_ena = 1'b1; gold_reg = 5'd4; gold_value = 32'd4; gold_last = 1'b0;
    #1;
    tests++;
    if (gold_ready !== 1'b0) begin
      fails++;
      $display("FAIL fail_terminal_ready: got %b required 0", gold_ready);
    end
    @(negedge clk_i);
    gold_valid = 1'b0;
    tests++;
    if (chk_pass_cnt !== 32'd2 || chk_fail !== 1'b1 || err_pc !== 32'h8) begin
      fails++;
      $display("FAIL fail_terminal_hold: cnt=%0d fail=%b err_pc=%h required 2/1/8",
               chk_pass_cnt, chk_fail, err_pc);
    end
  endtask

  task automatic test_dont_care();
    do_reset();
    commit(32'h0, 1'b1, 5'd0, 32'hDEAD);
    commit(32'h4, 1'b0, 5'($urandom), $urandom);
    commit(32'h8, 1'b1, 5'd2, 32'd5);
    gold_xfer(32'h0, 1'b1, 5'd0, 32'h0, 1'b0);
    gold_xfer(32'h4, 1'b0, 5'($urandom), $urandom, 1'b0);
    gold_xfer(32'h8, 1'b0, 5'd2, 32'd5, 1'b0);
    tests++;
    if (chk_pass_cnt !== 32'd2 || chk_fail !== 1'b1 || err_pc !== m_err_pc ||
        err_reg !== m_err_reg || err_exp_value !== m_err_exp || err_got_value !== m_err_got) begin
      fails++;
      $display("FAIL dont_care: cnt=%0d fail=%b err_pc=%h required cnt=2 fail=1 err_pc=%h",
               chk_pass_cnt, chk_fail, err_pc, m_err_pc);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) commit(32'(16 * i), 1'b1, 5'(i + 1), 32'(100 + i));
    tests++;
    if (chk_overflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_at_depth: got %b required 0", chk_overflow);
    end
    commit(32'hFFF0, 1'b1, 5'd1, 32'h1);
    tests++;
    if (chk_overflow !== 1'b1 || chk_overflow !== m_ovf) begin
      fails++;
      $display("FAIL overflow_set: got %b required 1", chk_overflow);
    end
    for (int i = 0; i < DEPTH; i++)
      gold_xfer(32'(16 * i), 1'b1, 5'(i + 1), 32'(100 + i), i == DEPTH - 1);
    tests++;
    if (chk_pass_cnt !== 32'(DEPTH) || chk_done !== 1'b1 || chk_overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_drain: cnt=%0d done=%b ovf=%b required %0d/1/1",
               chk_pass_cnt, chk_done, chk_overflow, DEPTH);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) commit(32'(4 * i), 1'b1, 5'(i + 1), 32'(i));
      else begin
        fork
          commit(32'(4 * i), 1'b1, 5'(i + 1), 32'(i));
          gold_xfer(32'h0, 1'b1, 5'd1, 32'd0, 1'b0);
        join
      end
    end
    tests++;
    if (chk_overflow !== 1'b0 || chk_pass_cnt !== 32'd1) begin
      fails++;
      $display("FAIL full_push_pop: ovf=%b cnt=%0d required 0/1", chk_overflow, chk_pass_cnt);
    end
    commit(32'hABC0, 1'b1, 5'd7, 32'h7);
    tests++;
    if (chk_overflow !== 1'b1) begin
      fails++;
      $display("FAIL full_still_full: ovf=%b required 1", chk_overflow);
    end
    for (int i = 1; i <= DEPTH; i++) gold_xfer(32'(4 * i), 1'b1, 5'(i + 1), 32'(i), i == DEPTH);
    tests++;
    if (chk_pass_cnt !== 32'(DEPTH + 1) || chk_done !== 1'b1) begin
      fails++;
      $display("FAIL full_drain: cnt=%0d done=%b required %0d/1", chk_pass_cnt, chk_done, DEPTH + 1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    waits = 0;
    fork
      for (int i = 0; i < 6; i++) commit(32'h1000 + 32'(4 * i), 1'b1, 5'(i + 10), 32'(i * 3));
      for (int i = 0; i < 6; i++)
        gold_xfer(32'h1000 + 32'(4 * i), 1'b1, 5'(i + 10), 32'(i * 3), i == 5);
    join
    tests++;
    if (waits != 1 || chk_pass_cnt !== 32'd6 || chk_done !== 1'b1) begin
      fails++;
      $display("FAIL back_to_back: stalls=%0d cnt=%0d done=%b required 1/6/1",
               waits, chk_pass_cnt, chk_done);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int i = 0; i < 4; i++) commit(32'(4 * i), 1'b1, 5'(i + 1), 32'(i));
    gold_xfer(32'h100, 1'b1, 5'd1, 32'd0, 1'b0);
    gold_valid = 1'b1;
    gold_pc = 32'h4; gold_ena = 1'b1; gold_reg = 5'd2; gold_value = 32'd1; gold_last = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    tests++;
    if ({gold_ready, chk_done, chk_fail, chk_overflow} !== 4'b0 || chk_pass_cnt !== '0 ||
        err_pc !== '0 || err_reg !== '0 || err_exp_value !== '0 || err_got_value !== '0) begin
      fails++;
      $display("FAIL reset_mid_run: rdy=%b done=%b fail=%b ovf=%b cnt=%0d err_pc=%h required all zero",
               gold_ready, chk_done, chk_fail, chk_overflow, chk_pass_cnt, err_pc);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst = 1'b0;
    #1;
    tests++;
    if (gold_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_flush: rdy=%b required 0", gold_ready);
    end
    @(negedge clk_i);
    gold_valid = 1'b0;
    commit(32'h200, 1'b1, 5'd5, 32'h55);
    commit(32'h204, 1'b1, 5'd6, 32'h66);
    gold_xfer(32'h200, 1'b1, 5'd5, 32'h55, 1'b0);
    gold_xfer(32'h204, 1'b1, 5'd6, 32'h66, 1'b1);
    tests++;
    if (chk_pass_cnt !== 32'd2 || chk_done !== 1'b1) begin
      fails++;
      $display("FAIL reset_restart: cnt=%0d done=%b required 2/1", chk_pass_cnt, chk_done);
    end
  endtask

  initial begin
    debug_wb_have_inst = 1'b0;
    debug_wb_pc = '0; debug_wb_ena = 1'b0; debug_wb_reg = '0; debug_wb_value = '0;
    gold_valid = 1'b0;
    gold_pc = '0; gold_ena = 1'b0; gold_reg = '0; gold_value = '0; gold_last = 1'b0;
    rst = 1'b1;
    @(negedge clk_i);
    test_reset();
    test_match_stream();
    test_value_mismatch();
    test_dont_care();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
